// File: rtl/router_reg.sv
// router_reg: 1x3 router datapath register stage (header latch, full-park byte, parity tracking).
// Define ROUTER_REG_PARITY_CHK_EN to build the int_par/pkt_par compare that drives err.
module router_reg #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             pkt_valid,
    input  logic [WIDTH-1:0] data_in,
    input  logic             fifo_full,
    input  logic             detect_add,
    input  logic             lfd_state,
    input  logic             ld_state,
    input  logic             full_state,
    input  logic             laf_state,
    input  logic             rst_int_reg,
    output logic [WIDTH-1:0] dout,
    output logic             parity_done,
    output logic             low_pkt_valid,
    output logic             err
);

    logic [WIDTH-1:0] dout_q, dout_d;
    logic [WIDTH-1:0] hdr_q, hdr_d;
    logic [WIDTH-1:0] hold_q, hold_d;
    logic             parity_done_q, parity_done_d;
    logic             low_pkt_valid_q, low_pkt_valid_d;
`ifdef ROUTER_REG_PARITY_CHK_EN
    logic [WIDTH-1:0] int_par_q, int_par_d;
    logic [WIDTH-1:0] pkt_par_q, pkt_par_d;
    logic             err_q, err_d;
`endif

    always_comb begin
        // NOTE: every _d starts as its _q, so a path that assigns nothing holds state instead of inferring a latch.
        dout_d          = dout_q;
        hdr_d           = hdr_q;
        hold_d          = hold_q;
        parity_done_d   = parity_done_q;
        low_pkt_valid_d = low_pkt_valid_q;
`ifdef ROUTER_REG_PARITY_CHK_EN
        int_par_d       = int_par_q;
        pkt_par_d       = pkt_par_q;
        err_d           = err_q;
`endif

        if (full_state) begin
            // FIFO_FULL_STATE: everything holds while the target FIFO drains
        end else if (detect_add) begin
            if (pkt_valid && (data_in[1:0] != 2'b11)) begin
                hdr_d = data_in;
            end
            parity_done_d = 1'b0;
`ifdef ROUTER_REG_PARITY_CHK_EN
            if (pkt_valid) begin
                err_d = 1'b0;
            end
`endif
        end else if (lfd_state) begin
            dout_d = hdr_q;
`ifdef ROUTER_REG_PARITY_CHK_EN
            int_par_d = hdr_q;
`endif
        end else if (ld_state) begin
            if (fifo_full) begin
                hold_d = data_in;
            end else begin
                dout_d = data_in;
            end
`ifdef ROUTER_REG_PARITY_CHK_EN
            if (pkt_valid) begin
                int_par_d = int_par_q ^ data_in;
            end
`endif
            // pkt_valid low marks the trailing parity byte
            if (!pkt_valid) begin
                low_pkt_valid_d = 1'b1;
                if (!fifo_full) begin
                    parity_done_d = 1'b1;
`ifdef ROUTER_REG_PARITY_CHK_EN
                    pkt_par_d = data_in;
`endif
                end
            end
        end else if (laf_state) begin
            dout_d = hold_q;
            // A parked parity byte is only now being delivered
            if (low_pkt_valid_q && !parity_done_q) begin
                parity_done_d = 1'b1;
`ifdef ROUTER_REG_PARITY_CHK_EN
                pkt_par_d = hold_q;
`endif
            end
        end else if (rst_int_reg) begin
            low_pkt_valid_d = 1'b0;
`ifdef ROUTER_REG_PARITY_CHK_EN
            err_d = (int_par_q != pkt_par_q);
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dout_q          <= '0;
            hdr_q           <= '0;
            hold_q          <= '0;
            parity_done_q   <= 1'b0;
            low_pkt_valid_q <= 1'b0;
`ifdef ROUTER_REG_PARITY_CHK_EN
            int_par_q       <= '0;
            pkt_par_q       <= '0;
            err_q           <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every register samples the pre-edge values.
            dout_q          <= dout_d;
            hdr_q           <= hdr_d;
            hold_q          <= hold_d;
            parity_done_q   <= parity_done_d;
            low_pkt_valid_q <= low_pkt_valid_d;
`ifdef ROUTER_REG_PARITY_CHK_EN
            int_par_q       <= int_par_d;
            pkt_par_q       <= pkt_par_d;
            err_q           <= err_d;
`endif
        end
    end

    assign dout          = dout_q;
    assign parity_done   = parity_done_q;
    assign low_pkt_valid = low_pkt_valid_q;
`ifdef ROUTER_REG_PARITY_CHK_EN
    assign err           = err_q;
`else
    assign err           = 1'b0;
`endif

endmodule

// File: tb/tb_router_reg.sv
// Directed bench for router_reg: strobes driven per controller state, dout checked via an expected-byte queue.
module tb_router_reg;

    localparam int WIDTH = 8;
`ifdef ROUTER_REG_PARITY_CHK_EN
    localparam logic PAR_EN = 1'b1;
`else
    localparam logic PAR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {ST_IDLE, ST_DA, ST_LFD, ST_LD, ST_FULL, ST_LAF, ST_CPE} ctrl_e;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             pkt_valid = 1'b0;
    logic [WIDTH-1:0] data_in = '0;
    logic             fifo_full = 1'b0;
    logic             detect_add = 1'b0;
    logic             lfd_state = 1'b0;
    logic             ld_state = 1'b0;
    logic             full_state = 1'b0;
    logic             laf_state = 1'b0;
    logic             rst_int_reg = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             parity_done;
    logic             low_pkt_valid;
    logic             err;

    int               n_tests = 0;
    int               n_fail = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] m_hdr = '0;
    logic [WIDTH-1:0] m_hold = '0;
    logic [WIDTH-1:0] m_dout = '0;

    router_reg #(.WIDTH(WIDTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .pkt_valid    (pkt_valid),
        .data_in      (data_in),
        .fifo_full    (fifo_full),
        .detect_add   (detect_add),
        .lfd_state    (lfd_state),
        .ld_state     (ld_state),
        .full_state   (full_state),
        .laf_state    (laf_state),
        .rst_int_reg  (rst_int_reg),
        .dout         (dout),
        .parity_done  (parity_done),
        .low_pkt_valid(low_pkt_valid),
        .err          (err)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "bench did not finish");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_strobes(input ctrl_e s);
        detect_add  = (s == ST_DA);
        lfd_state   = (s == ST_LFD);
        ld_state    = (s == ST_LD);
        full_state  = (s == ST_FULL);
        laf_state   = (s == ST_LAF);
        rst_int_reg = (s == ST_CPE);
    endtask

    task automatic do_reset(input int n);
        rst         = 1'b0;
        data_in     = 8'hFF;
        pkt_valid   = 1'b1;
        fifo_full   = 1'b1;
        detect_add  = 1'b1;
        lfd_state   = 1'b1;
        ld_state    = 1'b1;
        full_state  = 1'b1;
        laf_state   = 1'b1;
        rst_int_reg = 1'b1;
        repeat (n) tick();
        m_hdr  = '0;
        m_hold = '0;
        m_dout = '0;
        exp_q.delete();
        rst = 1'b1;
        set_strobes(ST_IDLE);
        pkt_valid = 1'b0;
        fifo_full = 1'b0;
    endtask

    // One controller cycle; bytes headed for the FIFO port are queued now and compared after the edge
    task automatic step(input ctrl_e s, input logic pv, input logic [WIDTH-1:0] din,
                        input logic full, input string tag);
        logic produces;
        set_strobes(s);
        pkt_valid = pv;
        data_in   = din;
        fifo_full = full;
        produces  = (s == ST_LFD) || (s == ST_LD && !full) || (s == ST_LAF);
        if (s == ST_LFD) exp_q.push_back(m_hdr);
        else if (s == ST_LD && !full) exp_q.push_back(din);
        else if (s == ST_LAF) exp_q.push_back(m_hold);
        if (s == ST_LD && full) m_hold = din;
        if (s == ST_DA && pv && (din[1:0] != 2'b11)) m_hdr = din;
        tick();
        if (produces && exp_q.size() > 0) begin
            m_dout = exp_q.pop_front();
            check({tag, " dout"}, 32'(dout), 32'(m_dout));
        end else begin
            check({tag, " dout held"}, 32'(dout), 32'(m_dout));
        end
    endtask

    initial begin
        // Reset with every input forced high
        do_reset(2);
        check("rst dout", 32'(dout), 32'h0);
        check("rst parity_done", 32'(parity_done), 32'h0);
        check("rst low_pkt_valid", 32'(low_pkt_valid), 32'h0);
        check("rst err", 32'(err), 32'h0);

        // Clean packet 0D 11 22 / parity 3E
        step(ST_DA,   1'b1, 8'h0D, 1'b0, "clean da");
        check("clean da parity_done", 32'(parity_done), 32'h0);
        step(ST_LFD,  1'b1, 8'h11, 1'b0, "clean lfd");
        step(ST_LD,   1'b1, 8'h11, 1'b0, "clean ld0");
        step(ST_LD,   1'b1, 8'h22, 1'b0, "clean ld1");
        step(ST_LD,   1'b0, 8'h3E, 1'b0, "clean par");
        check("clean parity_done", 32'(parity_done), 32'h1);
        check("clean low_pkt_valid", 32'(low_pkt_valid), 32'h1);
        step(ST_IDLE, 1'b0, 8'h00, 1'b0, "clean lp");
        check("clean lp parity_done", 32'(parity_done), 32'h1);
        step(ST_CPE,  1'b0, 8'h00, 1'b0, "clean cpe");
        check("clean cpe low_pkt_valid", 32'(low_pkt_valid), 32'h0);
        check("clean err", 32'(err), 32'h0);

        // Corrupt parity byte 3F
        step(ST_DA,   1'b1, 8'h0D, 1'b0, "bad da");
        check("bad da parity_done", 32'(parity_done), 32'h0);
        step(ST_LFD,  1'b1, 8'h11, 1'b0, "bad lfd");
        step(ST_LD,   1'b1, 8'h11, 1'b0, "bad ld0");
        step(ST_LD,   1'b1, 8'h22, 1'b0, "bad ld1");
        step(ST_LD,   1'b0, 8'h3F, 1'b0, "bad par");
        check("bad parity_done", 32'(parity_done), 32'h1);
        step(ST_IDLE, 1'b0, 8'h00, 1'b0, "bad lp");
        step(ST_CPE,  1'b0, 8'h00, 1'b0, "bad cpe");
        check("bad err", 32'(err), 32'(PAR_EN));
        step(ST_IDLE, 1'b0, 8'h00, 1'b0, "bad idle0");
        step(ST_IDLE, 1'b0, 8'h00, 1'b0, "bad idle1");
        check("bad err sticky", 32'(err), 32'(PAR_EN));
        step(ST_DA,   1'b0, 8'h0D, 1'b0, "bad da nopv");
        check("bad err da nopv", 32'(err), 32'(PAR_EN));
        step(ST_DA,   1'b1, 8'h0D, 1'b0, "next da");
        check("err cleared", 32'(err), 32'h0);

        // FIFO full while 22 is in LOAD_DATA
        step(ST_LFD,  1'b1, 8'h11, 1'b0, "fmid lfd");
        step(ST_LD,   1'b1, 8'h11, 1'b0, "fmid ld0");
        step(ST_LD,   1'b1, 8'h22, 1'b1, "fmid ld1 full");
        for (int i = 0; i < 3; i++) step(ST_FULL, 1'b1, 8'h22, 1'b1, "fmid full");
        check("fmid dout in full", 32'(dout), 32'h11);
        step(ST_LAF,  1'b1, 8'h22, 1'b0, "fmid laf");
        check("fmid laf dout", 32'(dout), 32'h22);
        step(ST_LD,   1'b0, 8'h3E, 1'b0, "fmid par");
        check("fmid parity_done", 32'(parity_done), 32'h1);
        step(ST_IDLE, 1'b0, 8'h00, 1'b0, "fmid lp");
        step(ST_CPE,  1'b0, 8'h00, 1'b0, "fmid cpe");
        check("fmid err", 32'(err), 32'h0);

        // FIFO full on the parity byte
        step(ST_DA,   1'b1, 8'h0D, 1'b0, "fpar da");
        step(ST_LFD,  1'b1, 8'h11, 1'b0, "fpar lfd");
        step(ST_LD,   1'b1, 8'h11, 1'b0, "fpar ld0");
        step(ST_LD,   1'b1, 8'h22, 1'b0, "fpar ld1");
        step(ST_LD,   1'b0, 8'h3E, 1'b1, "fpar par full");
        check("fpar low_pkt_valid", 32'(low_pkt_valid), 32'h1);
        check("fpar parity_done low", 32'(parity_done), 32'h0);
        step(ST_FULL, 1'b0, 8'h3E, 1'b1, "fpar full0");
        step(ST_FULL, 1'b0, 8'h3E, 1'b1, "fpar full1");
        check("fpar full parity_done", 32'(parity_done), 32'h0);
        step(ST_LAF,  1'b0, 8'h3E, 1'b0, "fpar laf");
        check("fpar laf dout", 32'(dout), 32'h3E);
        check("fpar laf parity_done", 32'(parity_done), 32'h1);
        step(ST_IDLE, 1'b0, 8'h00, 1'b0, "fpar lp");
        step(ST_CPE,  1'b0, 8'h00, 1'b0, "fpar cpe");
        check("fpar err", 32'(err), 32'h0);
        check("fpar cpe low_pkt_valid", 32'(low_pkt_valid), 32'h0);

        // Address 11 and pkt_valid-low headers leave hdr untouched
        step(ST_DA,   1'b1, 8'h03, 1'b0, "inv da");
        step(ST_LFD,  1'b1, 8'h00, 1'b0, "inv lfd");
        check("inv lfd dout", 32'(dout), 32'h0D);
        step(ST_DA,   1'b0, 8'h0A, 1'b0, "nopv da");
        step(ST_LFD,  1'b1, 8'h00, 1'b0, "nopv lfd");
        step(ST_DA,   1'b1, 8'h06, 1'b0, "new da");
        step(ST_LFD,  1'b1, 8'h00, 1'b0, "new lfd");
        check("new lfd dout", 32'(dout), 32'h06);

        // Reset mid-packet discards the parked byte and flags
        step(ST_DA,   1'b1, 8'h09, 1'b0, "mrst da");
        step(ST_LFD,  1'b1, 8'h11, 1'b0, "mrst lfd");
        step(ST_LD,   1'b1, 8'h11, 1'b1, "mrst ld full");
        step(ST_LD,   1'b0, 8'h3E, 1'b1, "mrst par full");
        check("mrst low_pkt_valid pre", 32'(low_pkt_valid), 32'h1);
        do_reset(1);
        check("mrst dout", 32'(dout), 32'h0);
        check("mrst low_pkt_valid", 32'(low_pkt_valid), 32'h0);
        step(ST_LAF,  1'b0, 8'h00, 1'b0, "mrst laf");
        check("mrst laf parity_done", 32'(parity_done), 32'h0);
        step(ST_LFD,  1'b1, 8'h00, 1'b0, "mrst lfd hdr");

        check("scoreboard drained", 32'(exp_q.size()), 32'h0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
